// File: rtl/dm163_pkg.sv
// -----------------------------------------------------------------------------
// dm163_pkg
// Shared constants and types for the DM163 colorshield row scanner.
//   N_ROWS / N_COLS  : matrix geometry (8x8)
//   BITS_PER_PIXEL   : serial bits per RGB pixel (3 x 8)
//   state_e          : row-scan FSM state encoding
//   cnt_width()      : counter width helper that never returns zero
// -----------------------------------------------------------------------------
package dm163_pkg;

  localparam int N_ROWS         = 8;
  localparam int N_COLS         = 8;
  localparam int BITS_PER_PIXEL = 24;

  localparam int ROW_W = $clog2(N_ROWS);
  localparam int COL_W = $clog2(N_COLS);
  localparam int BIT_W = $clog2(BITS_PER_PIXEL);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_LATCH   = 3'd4,
    ST_DISPLAY = 3'd5
  } state_e;

  // A modulus of 1 still needs a 1-bit counter that simply stays at 0.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm163_shift_out.sv
// -----------------------------------------------------------------------------
// dm163_shift_out
// Parallel-load 24-bit serializer for the DM163 SCK/SDA interface.
// Bit 23 of the loaded word goes out first. Each bit shows sda with sck low
// for CLK_DIV clocks, then sck high for CLK_DIV clocks; the register only
// shifts at the end of a high phase, so sda never moves while sck is high.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous active-high reset
//   i_load   capture i_din into the shift register
//   i_din    24-bit word, bit 23 shifted first
//   i_start  begin a 24-bit transfer (low phase of bit 23 starts next clk)
//   o_sck    DM163 serial clock
//   o_sda    DM163 serial data (held low when idle)
//   o_done   1-clk pulse on the final clk of the last high phase, so the
//            controller leaves its shift state exactly as sck drops
// -----------------------------------------------------------------------------
module dm163_shift_out
  import dm163_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load,
  input  logic [BITS_PER_PIXEL-1:0] i_din,
  input  logic                      i_start,
  output logic                      o_sck,
  output logic                      o_sda,
  output logic                      o_done
);

  localparam int                   DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(BITS_PER_PIXEL - 1);

  logic [BITS_PER_PIXEL-1:0] r_sreg;
  logic [DIV_W-1:0]          r_div;
  logic [BIT_W-1:0]          r_bit;
  logic                      r_active;
  logic                      r_phase;   // 0 = sck low half, 1 = sck high half

  logic w_div_last;
  logic w_bit_last;

  assign w_div_last = (r_div == DIV_LAST);
  assign w_bit_last = (r_bit == BIT_LAST);

  assign o_sck  = r_active & r_phase;
  assign o_sda  = r_active & r_sreg[BITS_PER_PIXEL-1];
  assign o_done = r_active & r_phase & w_div_last & w_bit_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the data register is reset too, so an abandoned transfer can
      // never leak stale bits onto sda after reset.
      r_sreg   <= '0;
      r_div    <= '0;
      r_bit    <= '0;
      r_active <= 1'b0;
      r_phase  <= 1'b0;
    end else begin
      if (i_load) begin
        r_sreg <= i_din;
      end
      if (i_start) begin
        r_active <= 1'b1;
        r_phase  <= 1'b0;
        r_div    <= '0;
        r_bit    <= '0;
      end else if (r_active) begin
        if (w_div_last) begin
          r_div <= '0;
          if (r_phase) begin
            r_phase <= 1'b0;
            r_sreg  <= {r_sreg[BITS_PER_PIXEL-2:0], 1'b0};
            if (w_bit_last) begin
              r_active <= 1'b0;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_phase <= 1'b1;
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dm163_row_scanner.sv
// -----------------------------------------------------------------------------
// dm163_row_scanner
// Row-scan sequencer for the DM163 8x8 RGB colorshield. Per row: fetch each
// pixel (col 7 down to 0), serialize it B,G,R MSB-first, pulse lat, then
// enable the row for HOLD_CYCLES clocks before moving on.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_enable   run scan; sampled in IDLE and at the end of DISPLAY only
//   o_rd_addr  frame buffer address {row, col}, non-zero only during FETCH
//   o_rd_en    read strobe; i_rd_data is valid one clk later
//   i_rd_data  pixel {R, G, B}
//   o_sck      DM163 serial clock
//   o_sda      DM163 serial data
//   o_lat      DM163 latch, 1-clk pulse
//   o_row_idx  row currently latched / displayed
//   o_row_en   high only while the row is displayed (blanks during shifting)
// -----------------------------------------------------------------------------
module dm163_row_scanner
  import dm163_pkg::*;
#(
  parameter int CLK_DIV     = 1,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  output logic [ROW_W+COL_W-1:0]    o_rd_addr,
  output logic                      o_rd_en,
  input  logic [BITS_PER_PIXEL-1:0] i_rd_data,
  output logic                      o_sck,
  output logic                      o_sda,
  output logic                      o_lat,
  output logic [ROW_W-1:0]          o_row_idx,
  output logic                      o_row_en
);

  localparam int               HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(N_COLS - 1);

  state_e            r_state;
  state_e            w_next;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [HOLD_W-1:0] r_hold;
  logic [ROW_W-1:0]  r_row_idx;

  logic                      w_load;
  logic                      w_done;
  logic                      w_hold_last;
  logic [BITS_PER_PIXEL-1:0] w_bgr;

  assign w_hold_last = (r_hold == HOLD_LAST);
  assign o_row_idx   = r_row_idx;

  // The DM163 expects blue first, so reorder {R,G,B} into {B,G,R}.
  assign w_bgr = {i_rd_data[7:0], i_rd_data[15:8], i_rd_data[23:16]};

  dm163_shift_out #(
    .CLK_DIV (CLK_DIV)
  ) u_shift_out (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_din   (w_bgr),
    .i_start (w_load),
    .o_sck   (o_sck),
    .o_sda   (o_sda),
    .o_done  (w_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    o_rd_en   = 1'b0;
    o_rd_addr = '0;
    o_lat     = 1'b0;
    o_row_en  = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_rd_en   = 1'b1;
        o_rd_addr = {r_row, r_col};
        w_next    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_load = 1'b1;
        w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_done) begin
          w_next = (r_col != '0) ? ST_FETCH : ST_LATCH;
        end
      end
      ST_LATCH: begin
        o_lat  = 1'b1;
        w_next = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        o_row_en = 1'b1;
        if (w_hold_last) begin
          w_next = i_enable ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row     <= '0;
      r_col     <= COL_LAST;
      r_hold    <= '0;
      r_row_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A restart after stopping always begins a fresh frame.
          r_row <= '0;
          r_col <= COL_LAST;
        end
        ST_SHIFT: begin
          if (w_done) begin
            if (r_col != '0) begin
              r_col <= r_col - 1'b1;
            end else begin
              // Loaded on entry to LATCH so row_idx changes with the latch.
              r_row_idx <= r_row;
            end
          end
        end
        ST_LATCH: begin
          r_hold <= '0;
        end
        ST_DISPLAY: begin
          if (w_hold_last) begin
            r_row <= r_row + 1'b1;
            r_col <= COL_LAST;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm163_row_scanner.sv
// -----------------------------------------------------------------------------
// tb_dm163_row_scanner
// Directed bench for dm163_row_scanner. One instance runs at CLK_DIV=1,
// HOLD_CYCLES=4; a second runs at CLK_DIV=3, HOLD_CYCLES=2. Negedge monitors
// log fetches, serial bits, latch pulses and row-enable runs; each test task
// compares those logs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dm163_row_scanner;

  localparam int HOLD  = 4;
  localparam int HOLD3 = 2;
  localparam int T_ROW = 8 * 50 + 1 + HOLD;  // 405

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [5:0]  rd_addr;
  logic        rd_en;
  logic [23:0] rd_data = '0;
  logic        sck, sda, lat, row_en;
  logic [2:0]  row_idx;

  logic        rst3 = 1'b1;
  logic        enable3 = 1'b0;
  logic [5:0]  rd_addr3;
  logic        rd_en3;
  logic [23:0] rd_data3 = '0;
  logic        sck3, sda3, lat3, row_en3;
  logic [2:0]  row_idx3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm163_row_scanner #(.CLK_DIV(1), .HOLD_CYCLES(HOLD)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable),
    .o_rd_addr(rd_addr), .o_rd_en(rd_en), .i_rd_data(rd_data),
    .o_sck(sck), .o_sda(sda), .o_lat(lat),
    .o_row_idx(row_idx), .o_row_en(row_en)
  );

  dm163_row_scanner #(.CLK_DIV(3), .HOLD_CYCLES(HOLD3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_enable(enable3),
    .o_rd_addr(rd_addr3), .o_rd_en(rd_en3), .i_rd_data(rd_data3),
    .o_sck(sck3), .o_sda(sda3), .o_lat(lat3),
    .o_row_idx(row_idx3), .o_row_en(row_en3)
  );

  // Frame buffer model: address-tagged pixels, with (row0,col7) = FF0081.
  function automatic logic [23:0] pix(input logic [5:0] a);
    if (a == 6'd7) return 24'hFF0081;
    return {2'b11, a, 2'b00, a, 2'b01, a};
  endfunction

  always @(posedge clk) if (rd_en)  rd_data  <= pix(rd_addr);
  always @(posedge clk) if (rd_en3) rd_data3 <= pix(rd_addr3);

  // ---------------- monitor, CLK_DIV=1 instance ----------------
  int q_addr[$], q_rcyc[$], q_lat_cyc[$], q_lat_row[$], q_lat_bits[$];
  int q_runs[$], q_run_row[$];
  bit q_bits[$];
  int n_lat_hi = 0, en_run = 0, viol_en = 0, viol_sda = 0;
  bit p_sck = 0, p_sda = 0, p_lat = 0, p_en = 0;
  logic [2:0] p_row = '0;

  always @(negedge clk) begin
    if (rd_en) begin
      q_addr.push_back(int'(rd_addr));
      q_rcyc.push_back(cyc);
    end
    if (sck && !p_sck) q_bits.push_back(sda);
    if (p_sck && sck && (sda != p_sda)) viol_sda++;
    if (lat) begin
      n_lat_hi++;
      if (!p_lat) begin
        q_lat_cyc.push_back(cyc);
        q_lat_row.push_back(int'(row_idx));
        q_lat_bits.push_back(q_bits.size());
      end
    end
    if (row_en) begin
      en_run++;
      if (sck || rd_en || lat) viol_en++;
    end else if (p_en) begin
      q_runs.push_back(en_run);
      q_run_row.push_back(int'(p_row));
      en_run = 0;
    end
    p_sck = sck; p_sda = sda; p_lat = lat; p_en = row_en; p_row = row_idx;
  end

  // ---------------- monitor, CLK_DIV=3 instance ----------------
  int q_fetch3[$], q_rise3[$], q_hi3[$], q_lat3[$];
  bit q_bits3[$];
  int hi_run3 = 0, viol_sda3 = 0;
  bit p_sck3 = 0, p_sda3 = 0, p_lat3 = 0;

  always @(negedge clk) begin
    if (rd_en3) q_fetch3.push_back(cyc);
    if (sck3) begin
      hi_run3++;
      if (!p_sck3) begin
        q_bits3.push_back(sda3);
        q_rise3.push_back(cyc);
      end else if (sda3 != p_sda3) begin
        viol_sda3++;
      end
    end else if (p_sck3) begin
      q_hi3.push_back(hi_run3);
      hi_run3 = 0;
    end
    if (lat3 && !p_lat3) q_lat3.push_back(cyc);
    p_sck3 = sck3; p_sda3 = sda3; p_lat3 = lat3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    n_tests++;
    if (rd_addr !== 6'd0) begin
      n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr);
    end
    n_tests++;
    if ({rd_en, sck, sda, lat, row_en} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 00000", {rd_en, sck, sda, lat, row_en});
    end
    n_tests++;
    if (row_idx !== 3'd0) begin
      n_fail++; $display("FAIL reset_row_idx: got %0d want 0", row_idx);
    end
    rst = 1'b0;
    repeat (5) tick();
    n_tests++;
    if ({rd_en, sck, lat, row_en} !== 4'b0) begin
      n_fail++; $display("FAIL idle_hold: got %b want 0000 with enable low", {rd_en, sck, lat, row_en});
    end
  endtask

  // Address order, pixel spacing, bit order, lat timing, row_en and wrap.
  task automatic test_scan();
    int b_a, b_l, b_b, b_r, b_h, exp_addr, exp_gap;
    logic [23:0] got;
    do_reset();
    b_a = q_addr.size(); b_l = q_lat_cyc.size(); b_b = q_bits.size();
    b_r = q_runs.size(); b_h = n_lat_hi;
    enable = 1'b1;
    for (int i = 0; i < 4000 && q_lat_cyc.size() < b_l + 9; i++) tick();
    n_tests++;
    if (q_lat_cyc.size() < b_l + 9) begin
      n_fail++; $display("FAIL scan_timeout: got %0d lat pulses want 9", q_lat_cyc.size() - b_l);
      return;
    end
    for (int k = 0; k < 64; k++) begin
      exp_addr = (k / 8) * 8 + 7 - (k % 8);
      n_tests++;
      if (q_addr[b_a + k] != exp_addr) begin
        n_fail++; $display("FAIL scan_addr[%0d]: got %0d want %0d", k, q_addr[b_a + k], exp_addr);
      end
    end
    for (int k = 0; k < 63; k++) begin
      exp_gap = (k % 8 == 7) ? 55 : 50;
      n_tests++;
      if (q_rcyc[b_a + k + 1] - q_rcyc[b_a + k] != exp_gap) begin
        n_fail++; $display("FAIL scan_fetch_gap[%0d]: got %0d want %0d", k,
                           q_rcyc[b_a + k + 1] - q_rcyc[b_a + k], exp_gap);
      end
    end
    got = '0;
    for (int i = 0; i < 24; i++) got = {got[22:0], q_bits[b_b + i]};
    n_tests++;
    if (got !== 24'h8100FF) begin
      n_fail++; $display("FAIL bit_order_px0: got %h want 8100ff", got);
    end
    got = '0;
    for (int i = 24; i < 48; i++) got = {got[22:0], q_bits[b_b + i]};
    n_tests++;
    if (got !== 24'h4606C6) begin
      n_fail++; $display("FAIL bit_order_px1: got %h want 4606c6", got);
    end
    for (int r = 0; r < 9; r++) begin
      n_tests++;
      if (q_lat_bits[b_l + r] - b_b != 192 * (r + 1)) begin
        n_fail++; $display("FAIL sck_rises_row%0d: got %0d want %0d", r,
                           q_lat_bits[b_l + r] - b_b, 192 * (r + 1));
      end
      n_tests++;
      if (q_lat_row[b_l + r] != r % 8) begin
        n_fail++; $display("FAIL lat_row_idx%0d: got %0d want %0d", r, q_lat_row[b_l + r], r % 8);
      end
      n_tests++;
      if (q_lat_cyc[b_l + r] - q_rcyc[b_a] != 400 + r * T_ROW) begin
        n_fail++; $display("FAIL lat_time_row%0d: got %0d want %0d", r,
                           q_lat_cyc[b_l + r] - q_rcyc[b_a], 400 + r * T_ROW);
      end
    end
    n_tests++;
    if (n_lat_hi - b_h != 9) begin
      n_fail++; $display("FAIL lat_width: got %0d high clks want 9", n_lat_hi - b_h);
    end
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (q_runs[b_r + r] != HOLD || q_run_row[b_r + r] != r) begin
        n_fail++; $display("FAIL row_en_run%0d: got len %0d row %0d want len %0d row %0d", r,
                           q_runs[b_r + r], q_run_row[b_r + r], HOLD, r);
      end
    end
  endtask

  task automatic test_enable_drop();
    int b_a, b_l, b_b, b_r, n_r;
    do_reset();
    b_a = q_addr.size(); b_l = q_lat_cyc.size(); b_b = q_bits.size(); b_r = q_runs.size();
    enable = 1'b1;
    for (int i = 0; i < 2000 && q_addr.size() < b_a + 28; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 500 && q_lat_cyc.size() < b_l + 4; i++) tick();
    n_tests++;
    if (q_lat_cyc.size() < b_l + 4) begin
      n_fail++; $display("FAIL drop_timeout: got %0d lat pulses want 4", q_lat_cyc.size() - b_l);
      return;
    end
    repeat (300) tick();
    n_tests++;
    if (q_addr.size() - b_a != 32) begin
      n_fail++; $display("FAIL drop_fetches: got %0d want 32", q_addr.size() - b_a);
    end
    n_tests++;
    if (q_lat_cyc.size() - b_l != 4 || q_lat_row[q_lat_row.size() - 1] != 3) begin
      n_fail++; $display("FAIL drop_lat: got %0d pulses last row %0d want 4 / 3",
                         q_lat_cyc.size() - b_l, q_lat_row[q_lat_row.size() - 1]);
    end
    n_r = q_runs.size();
    n_tests++;
    if (n_r - b_r != 4 || q_runs[n_r - 1] != HOLD || q_run_row[n_r - 1] != 3) begin
      n_fail++; $display("FAIL drop_display: got %0d runs last len %0d row %0d want 4 / %0d / 3",
                         n_r - b_r, q_runs[n_r - 1], q_run_row[n_r - 1], HOLD);
    end
    n_tests++;
    if (q_bits.size() - b_b != 768) begin
      n_fail++; $display("FAIL drop_bits: got %0d sck rises want 768", q_bits.size() - b_b);
    end
    n_tests++;
    if ({sck, lat, row_en, rd_en} !== 4'b0) begin
      n_fail++; $display("FAIL drop_idle: got %b want 0000", {sck, lat, row_en, rd_en});
    end
    enable = 1'b1;
    for (int i = 0; i < 10 && q_addr.size() < b_a + 33; i++) tick();
    n_tests++;
    if (q_addr.size() < b_a + 33 || q_addr[b_a + 32] != 7) begin
      n_fail++; $display("FAIL restart_addr: got fetches %0d want first addr 7", q_addr.size() - b_a);
    end
    for (int i = 0; i < 500 && q_lat_cyc.size() < b_l + 5; i++) tick();
    n_tests++;
    if (q_lat_cyc.size() < b_l + 5 || q_lat_row[b_l + 4] != 0) begin
      n_fail++; $display("FAIL restart_row: got %0d pulses want 5 with row 0", q_lat_cyc.size() - b_l);
    end
  endtask

  task automatic test_reset_mid_shift();
    int b_a, b_l;
    do_reset();
    b_a = q_addr.size(); b_l = q_lat_cyc.size();
    enable = 1'b1;
    for (int i = 0; i < 2500 && q_addr.size() < b_a + 41; i++) tick();
    n_tests++;
    if (q_addr.size() < b_a + 41 || q_addr[b_a + 40] != 47) begin
      n_fail++; $display("FAIL midrst_reach_row5: got %0d fetches want row5 col7 (47)", q_addr.size() - b_a);
      return;
    end
    repeat (10) tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({rd_addr, rd_en, sck, sda, lat, row_idx, row_en} !== 14'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got %b want all zero",
                         {rd_addr, rd_en, sck, sda, lat, row_idx, row_en});
    end
    rst = 1'b0;
    for (int i = 0; i < 10 && q_addr.size() < b_a + 42; i++) tick();
    n_tests++;
    if (q_addr.size() < b_a + 42 || q_addr[b_a + 41] != 7) begin
      n_fail++; $display("FAIL midrst_restart_addr: got %0d fetches want next addr 7", q_addr.size() - b_a);
      return;
    end
    n_tests++;
    if (q_lat_cyc.size() - b_l != 5) begin
      n_fail++; $display("FAIL midrst_no_lat: got %0d lat pulses want 5", q_lat_cyc.size() - b_l);
    end
    for (int i = 0; i < 500 && q_lat_cyc.size() < b_l + 6; i++) tick();
    n_tests++;
    if (q_lat_cyc.size() < b_l + 6 || q_lat_row[b_l + 5] != 0 ||
        q_lat_cyc[b_l + 5] - q_rcyc[b_a + 41] != 400) begin
      n_fail++; $display("FAIL midrst_rescan: got %0d pulses want row 0 latched 400 clks after restart",
                         q_lat_cyc.size() - b_l);
    end
  endtask

  task automatic test_clkdiv3();
    logic [23:0] got;
    int bad_hi, bad_gap;
    rst3 = 1'b0;
    enable3 = 1'b1;
    for (int i = 0; i < 1400 && q_lat3.size() < 1; i++) tick();
    n_tests++;
    if (q_lat3.size() < 1) begin
      n_fail++; $display("FAIL div3_timeout: got no lat pulse want 1");
      return;
    end
    n_tests++;
    if (q_bits3.size() != 192 || q_hi3.size() != 192) begin
      n_fail++; $display("FAIL div3_rises: got %0d rises %0d falls want 192", q_bits3.size(), q_hi3.size());
      return;
    end
    bad_hi = 0;
    bad_gap = 0;
    for (int k = 0; k < 192; k++) if (q_hi3[k] != 3) bad_hi++;
    for (int k = 0; k < 191; k++)
      if (k % 24 != 23 && q_rise3[k + 1] - q_rise3[k] != 6) bad_gap++;
    n_tests++;
    if (bad_hi != 0) begin
      n_fail++; $display("FAIL div3_high_len: got %0d phases not 3 clks want 0", bad_hi);
    end
    n_tests++;
    if (bad_gap != 0) begin
      n_fail++; $display("FAIL div3_period: got %0d bit periods not 6 clks want 0", bad_gap);
    end
    got = '0;
    for (int i = 0; i < 24; i++) got = {got[22:0], q_bits3[i]};
    n_tests++;
    if (got !== 24'h8100FF) begin
      n_fail++; $display("FAIL div3_bits: got %h want 8100ff", got);
    end
    n_tests++;
    if (q_fetch3[1] - q_fetch3[0] != 146) begin
      n_fail++; $display("FAIL div3_pixel: got %0d clks want 146", q_fetch3[1] - q_fetch3[0]);
    end
    n_tests++;
    if (q_lat3[0] - q_fetch3[0] != 1168) begin
      n_fail++; $display("FAIL div3_lat_time: got %0d want 1168", q_lat3[0] - q_fetch3[0]);
    end
    n_tests++;
    if (viol_sda3 != 0) begin
      n_fail++; $display("FAIL div3_sda_stable: got %0d changes while sck high want 0", viol_sda3);
    end
    enable3 = 1'b0;
  endtask

  task automatic test_invariants();
    n_tests++;
    if (viol_sda != 0) begin
      n_fail++; $display("FAIL sda_stable: got %0d changes while sck high want 0", viol_sda);
    end
    n_tests++;
    if (viol_en != 0) begin
      n_fail++; $display("FAIL row_en_blanking: got %0d overlaps with sck/rd_en/lat want 0", viol_en);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_enable_drop();
    test_reset_mid_shift();
    test_clkdiv3();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
